// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, multi-cycle MDU occupancy,
// fetch-stall and redirect flushing, plus a saturating stall-cycle counter.
module pipeline_hazard_ctrl #(
    parameter int MDU_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [4:0]       Rs1_ID,
    input  logic [4:0]       Rs2_ID,
    input  logic             ID_uses_rs1,
    input  logic             ID_uses_rs2,
    input  logic             ID_is_mdu,
    input  logic             ID_EX_MemRead,
    input  logic [4:0]       Rd_EX,
    input  logic             branch_taken_EX,
    input  logic             imem_ready,
    output logic             PC_Write,
    output logic             IF_ID_RegWrite,
    output logic             IF_Flush,
    output logic             ID_EX_Bubble,
    output logic             ID_EX_Hold,
    output logic             EX_MEM_Bubble,
    output logic             MDU_busy,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_LDUSE = 2'd1,
        ST_MDU   = 2'd2,
        ST_RSVD  = 2'd3
    } state_t;

    // Down-counter is wide enough for the largest legal MDU_LAT-2 (14).
    localparam int                DC_W     = 4;
    localparam logic [DC_W-1:0]   MDU_LOAD = DC_W'(MDU_LAT - 2);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    state_t            state_r;
    state_t            state_nxt_s;
    logic [DC_W-1:0]   mdu_cnt_r;
    logic [DC_W-1:0]   mdu_cnt_nxt_s;
    logic [CNT_W-1:0]  stall_cnt_r;

    logic hz_s;
    logic hz_eff_s;
    logic pc_write_s;
    logic ifid_write_s;
    logic if_flush_s;
    logic idex_bubble_s;
    logic idex_hold_s;
    logic exmem_bubble_s;
    logic mdu_busy_s;

    // Load-use hazard detect; x0 never creates a dependency.
    always_comb begin
        hz_s = ID_EX_MemRead && (Rd_EX != 5'd0) &&
               ((ID_uses_rs1 && (Rs1_ID == Rd_EX)) ||
                (ID_uses_rs2 && (Rs2_ID == Rd_EX)));
    end

    // Next-state and combinational pipeline controls.
    always_comb begin
        pc_write_s     = 1'b1;
        ifid_write_s   = 1'b1;
        if_flush_s     = 1'b0;
        idex_bubble_s  = 1'b0;
        idex_hold_s    = 1'b0;
        exmem_bubble_s = 1'b0;
        mdu_busy_s     = 1'b0;
        hz_eff_s       = 1'b0;
        state_nxt_s    = ST_RUN;
        mdu_cnt_nxt_s  = mdu_cnt_r;

        if (reset_n) begin
            pc_write_s     = 1'b0;
            ifid_write_s   = 1'b0;
            if_flush_s     = 1'b1;
            idex_bubble_s  = 1'b1;
            exmem_bubble_s = 1'b1;
            state_nxt_s    = ST_RUN;
            mdu_cnt_nxt_s  = {DC_W{1'b0}};
        end else begin
            case (state_r)
                ST_MDU: begin
                    pc_write_s     = 1'b0;
                    ifid_write_s   = 1'b0;
                    idex_hold_s    = 1'b1;
                    exmem_bubble_s = 1'b1;
                    mdu_busy_s     = 1'b1;
                    if (mdu_cnt_r == {DC_W{1'b0}}) begin
                        state_nxt_s   = ST_RUN;
                        mdu_cnt_nxt_s = {DC_W{1'b0}};
                    end else begin
                        state_nxt_s   = ST_MDU;
                        mdu_cnt_nxt_s = mdu_cnt_r - {{(DC_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    // RUN, LDUSE and the reserved code share RUN rules; LDUSE
                    // masks the hazard so each load-use inserts one bubble.
                    hz_eff_s = hz_s && (state_r != ST_LDUSE);
                    if (branch_taken_EX) begin
                        if_flush_s    = 1'b1;
                        idex_bubble_s = 1'b1;
                        state_nxt_s   = ST_RUN;
                    end else if (hz_eff_s) begin
                        pc_write_s    = 1'b0;
                        ifid_write_s  = 1'b0;
                        idex_bubble_s = 1'b1;
                        state_nxt_s   = ST_LDUSE;
                    end else begin
                        if (!imem_ready) begin
                            pc_write_s = 1'b0;
                            if_flush_s = 1'b1;
                        end else begin
                            pc_write_s = 1'b1;
                        end
                        if (ID_is_mdu) begin
                            state_nxt_s   = ST_MDU;
                            mdu_cnt_nxt_s = MDU_LOAD;
                        end else begin
                            state_nxt_s   = ST_RUN;
                        end
                    end
                end
            endcase
        end
    end

    // State and MDU down-counter registers.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            state_r   <= ST_RUN;
            mdu_cnt_r <= {DC_W{1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            mdu_cnt_r <= mdu_cnt_nxt_s;
        end
    end

    // Saturating count of cycles in which the PC was held.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (!pc_write_s && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign PC_Write       = pc_write_s;
    assign IF_ID_RegWrite = ifid_write_s;
    assign IF_Flush       = if_flush_s;
    assign ID_EX_Bubble   = idex_bubble_s;
    assign ID_EX_Hold     = idex_hold_s;
    assign EX_MEM_Bubble  = exmem_bubble_s;
    assign MDU_busy       = mdu_busy_s;
    assign state          = state_r;
    assign stall_count    = stall_cnt_r;

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter MDU_LAT, default 4, total EX occupancy in cycles of a multi-cycle (mul/div) op; legal range 2..16.
REQ-002 SHALL have parameter CNT_W, default 16, width of stall_count.
REQ-003 SHALL have port clk  in  1  sole clock, all state updates on posedge.
REQ-004 SHALL have port reset_n  in  1  reset, synchronous and active-high (asserted = 1, sampled on posedge clk).
REQ-005 SHALL have port Rs1_ID, Rs2_ID  in  5 each  source register indices of instruction in ID.
REQ-006 SHALL have port ID_uses_rs1, ID_uses_rs2  in  1 each  ID instruction actually reads that source.
REQ-007 SHALL have port ID_is_mdu  in  1  ID instruction is a multi-cycle op.
REQ-008 SHALL have port ID_EX_MemRead  in  1  EX instruction is a load.
REQ-009 SHALL have port Rd_EX  in  5  destination of EX instruction.
REQ-010 SHALL have port branch_taken_EX  in  1  taken branch/jump redirect resolved in EX.
REQ-011 SHALL have port imem_ready  in  1  fetch data valid this cycle.
REQ-012 SHALL have outputs PC_Write, IF_ID_RegWrite, IF_Flush, ID_EX_Bubble, ID_EX_Hold, EX_MEM_Bubble  out  1 each  pipeline-register controls.
REQ-013 SHALL have outputs MDU_busy  out  1; state  out  2 (RUN=0, LDUSE=1, MDU=2); stall_count  out  CNT_W.

Function
REQ-014 Control outputs SHALL be combinational from state and current inputs; state, down-counter and stall_count SHALL be registered.
REQ-015 hz SHALL = ID_EX_MemRead & (Rd_EX!=0) & ((ID_uses_rs1 & Rs1_ID==Rd_EX) | (ID_uses_rs2 & Rs2_ID==Rd_EX)).
REQ-016 Default (no condition below): PC_Write=1, IF_ID_RegWrite=1, all others 0.
REQ-017 RUN priority SHALL be: branch_taken_EX > hz > imem_ready==0 > ID_is_mdu.
REQ-018 RUN, branch_taken_EX=1: PC_Write=1, IF_ID_RegWrite=1, IF_Flush=1, ID_EX_Bubble=1; next RUN; hz and ID_is_mdu ignored.
REQ-019 RUN, hz=1: PC_Write=0, IF_ID_RegWrite=0, ID_EX_Bubble=1, IF_Flush=0; next LDUSE.
REQ-020 RUN, imem_ready=0 (no redirect, no hz): PC_Write=0, IF_Flush=1, others default; next RUN, or MDU if ID_is_mdu (REQ-021 applies to ID instruction).
REQ-021 RUN, ID_is_mdu=1: ID instruction issues (ID_EX_Bubble=0); next MDU, down-counter loaded MDU_LAT-2.
REQ-022 LDUSE: identical to RUN with hz forced 0 (exactly one load-use bubble per hazard); next per RUN rules.
REQ-023 MDU: PC_Write=0, IF_ID_RegWrite=0, ID_EX_Hold=1, EX_MEM_Bubble=1, MDU_busy=1, IF_Flush=0, ID_EX_Bubble=0; branch_taken_EX, hz, imem_ready ignored.
REQ-024 MDU: counter==0 -> next RUN; else decrement; MDU SHALL last exactly MDU_LAT-1 cycles.
REQ-025 stall_count SHALL increment each non-reset cycle with PC_Write=0, saturating at 2^CNT_W-1 (no wrap).
REQ-026 Unused state encoding 3 SHALL behave as RUN and next RUN.

Reset
REQ-027 reset_n=1 at posedge SHALL set state=RUN, counter=0, stall_count=0, overriding any in-flight MDU or LDUSE.
REQ-028 While reset_n=1: PC_Write=0, IF_ID_RegWrite=0, IF_Flush=1, ID_EX_Bubble=1, EX_MEM_Bubble=1, ID_EX_Hold=0, MDU_busy=0.
REQ-029 First cycle after reset_n falls SHALL follow RUN rules.

Verification
REQ-030 Load-use: ID_EX_MemRead=1, Rd_EX=5, Rs1_ID=5, ID_uses_rs1=1 -> one cycle PC_Write=0, IF_ID_RegWrite=0, ID_EX_Bubble=1; state 1 next; stall_count +1.
REQ-031 x0 / unused source: Rd_EX=0=Rs1_ID, or Rs2 match with ID_uses_rs2=0 -> no stall, default outputs.
REQ-032 MDU, MDU_LAT=4: ID_is_mdu=1 in RUN -> 3 cycles state=2, MDU_busy=1, EX_MEM_Bubble=1, PC_Write=0; then RUN; stall_count +3.
REQ-033 Simultaneous branch_taken_EX=1 and hz=1 -> IF_Flush=1, ID_EX_Bubble=1, PC_Write=1; next state RUN, stall_count unchanged.
REQ-034 reset_n=1 in 2nd MDU cycle -> next cycle state=0, MDU_busy=0, stall_count=0.
REQ-035 imem_ready=0 for 2 cycles in RUN -> IF_Flush=1, PC_Write=0 both cycles; stall_count +2.
